// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path (cache and memory responder).
package icache_pkg;

  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned LINE_BYTES  = 16;
  localparam int unsigned OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_RESP
  } state_t;

  typedef logic [32*LINE_WORDS-1:0] line_t;

  // Word k of a line occupies bits [32k+31:32k].
  function automatic line_t line_set_word(input line_t line, input logic [1:0] slot,
                                          input logic [31:0] word);
    line_t r;
    r = line;
    r[32*slot +: 32] = word;
    return r;
  endfunction

endpackage

// File: rtl/icache_line_responder_if.sv
// Refill request/response bundle between the instruction cache and its memory responder.
interface icache_line_responder_if;
  import icache_pkg::*;

  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        mem_ready_o;
  line_t       mem_data_o;
  logic        busy_o;
  logic        req_drop_o;

  modport master (
    output req_valid_i, req_addr_i,
    input  mem_ready_o, mem_data_o, busy_o, req_drop_o
  );

  modport slave (
    input  req_valid_i, req_addr_i,
    output mem_ready_o, mem_data_o, busy_o, req_drop_o
  );

endinterface

// File: rtl/mem_word_array.sv
// Word-organised backing store: asynchronous read, synchronous write, contents survive reset.
module mem_word_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_line_responder.sv
// Instruction-cache line refill responder: waits LAT_CYCLES, bursts four words, returns a 128-bit line.
module icache_line_responder
  import icache_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  parameter  int unsigned LAT_CYCLES  = 2,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  icache_line_responder_if.slave  bus,
  input  logic                    prog_we_i,
  input  logic [AW-1:0]           prog_addr_i,
  input  logic [31:0]             prog_data_i
);

  state_t            state;
  logic [3:0]        lat_cnt;
  logic [1:0]        beat;
  logic [AW-3:0]     line_idx;
  line_t             line_buf;
  logic              ready_q;
  line_t             data_q;
  logic              busy_q;
  logic              drop_q;
  logic [AW-1:0]     raddr;
  logic [31:0]       rdata;

  // Upper byte-address bits wrap away; low offset bits are forced to a line boundary.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr_i[31:AW+2], bus.req_addr_i[OFFSET_BITS-1:0]};

  assign raddr = {line_idx, beat};

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (prog_we_i),
    .waddr (prog_addr_i),
    .wdata (prog_data_i),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      beat     <= '0;
      line_idx <= '0;
      line_buf <= '0;
      ready_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      drop_q  <= bus.req_valid_i && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            line_idx <= bus.req_addr_i[AW+1:OFFSET_BITS];
            lat_cnt  <= 4'(LAT_CYCLES);
            beat     <= '0;
            busy_q   <= 1'b1;
            state    <= (LAT_CYCLES == 0) ? S_BURST : S_WAIT;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= S_BURST;
        end
        S_BURST: begin
          line_buf <= line_set_word(line_buf, beat, rdata);
          beat     <= beat + 2'd1;
          // The output line is captured together with the final beat so it is valid in RESP.
          if (beat == 2'd3) begin
            data_q  <= line_set_word(line_buf, beat, rdata);
            ready_q <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_ready_o = ready_q;
  assign bus.mem_data_o  = data_q;
  assign bus.busy_o      = busy_q;
  assign bus.req_drop_o  = drop_q;

endmodule

// File: tb/tb_icache_line_responder.sv
// Directed bench for icache_line_responder with a scoreboard of expected refill lines.
module tb_icache_line_responder;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_line_responder_if ia ();
  icache_line_responder_if ib ();

  logic        pa_we, pb_we;
  logic [9:0]  pa_addr, pb_addr;
  logic [31:0] pa_data, pb_data;

  icache_line_responder #(.DEPTH_WORDS(1024), .LAT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .bus(ia.slave),
    .prog_we_i(pa_we), .prog_addr_i(pa_addr), .prog_data_i(pa_data)
  );

  icache_line_responder #(.DEPTH_WORDS(1024), .LAT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .bus(ib.slave),
    .prog_we_i(pb_we), .prog_addr_i(pb_addr), .prog_data_i(pb_data)
  );

  int    npass  = 0;
  int    ntotal = 0;
  line_t exp_q[$];

  localparam line_t LINE_A  = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam line_t LINE_AD = 128'hDEADBEEF_A0000002_A0000001_A0000000;
  localparam line_t LINE_B  = 128'h00000004_00000003_00000002_00000001;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit sel, input logic v, input logic [31:0] a);
    if (sel) begin
      ib.req_valid_i = v;
      ib.req_addr_i  = a;
    end else begin
      ia.req_valid_i = v;
      ia.req_addr_i  = a;
    end
  endtask

  task automatic prog(input bit sel, input logic [9:0] a, input logic [31:0] d);
    if (sel) begin
      pb_we = 1'b1; pb_addr = a; pb_data = d;
    end else begin
      pa_we = 1'b1; pa_addr = a; pa_data = d;
    end
    tick();
    pa_we = 1'b0;
    pb_we = 1'b0;
  endtask

  // Cycle 0 is the request cycle; the caller has already ticked past it.
  task automatic window(input bit sel, input int ncyc, input int ready_cyc, input int busy_hi,
                        input int drop_cyc, input int req2_cyc, input int wr_cyc,
                        input logic [9:0] wr_addr, input logic [31:0] wr_data);
    logic  r, b, d;
    line_t data;
    for (int c = 1; c <= ncyc; c++) begin
      drive_req(sel, c == req2_cyc, 32'h0000_0080);
      if (!sel) begin
        pa_we   = (c == wr_cyc);
        pa_addr = wr_addr;
        pa_data = wr_data;
      end
      r    = sel ? ib.mem_ready_o : ia.mem_ready_o;
      b    = sel ? ib.busy_o      : ia.busy_o;
      d    = sel ? ib.req_drop_o  : ia.req_drop_o;
      data = sel ? ib.mem_data_o  : ia.mem_data_o;
      check($sformatf("ready c%0d", c), r, c == ready_cyc);
      check($sformatf("busy c%0d", c), b, c <= busy_hi);
      check($sformatf("drop c%0d", c), d, c == drop_cyc);
      if (r && exp_q.size() > 0) check($sformatf("line c%0d", c), data, exp_q.pop_front());
      tick();
    end
    pa_we = 1'b0;
    drive_req(sel, 1'b0, '0);
    check("scoreboard drained", 128'(exp_q.size()), '0);
  endtask

  task automatic request(input bit sel, input logic [31:0] a, input bit push, input line_t exp);
    drive_req(sel, 1'b1, a);
    if (push) exp_q.push_back(exp);
    tick();
    drive_req(sel, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    drive_req(1'b0, 1'b0, '0);
    drive_req(1'b1, 1'b0, '0);
    pa_we = 1'b0; pa_addr = '0; pa_data = '0;
    pb_we = 1'b0; pb_addr = '0; pb_data = '0;
    tick();
    tick();
    check("rst a ready", ia.mem_ready_o, 0);
    check("rst a busy",  ia.busy_o,      0);
    check("rst a drop",  ia.req_drop_o,  0);
    check("rst a data",  ia.mem_data_o,  0);
    check("rst b ready", ib.mem_ready_o, 0);
    check("rst b data",  ib.mem_data_o,  0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      prog(1'b0, 10'(16 + i), 32'hA000_0000 + 32'(i));
      prog(1'b1, 10'(i), 32'(i + 1));
    end

    // Zero-latency build
    request(1'b1, 32'h0000_0000, 1'b1, LINE_B);
    window(1'b1, 8, 5, 5, 0, -1, -1, '0, '0);

    // Aligned, unaligned and wrapped addresses all hit the same line
    request(1'b0, 32'h0000_0040, 1'b1, LINE_A);
    window(1'b0, 10, 7, 7, 0, -1, -1, '0, '0);
    request(1'b0, 32'h0000_004C, 1'b1, LINE_A);
    window(1'b0, 10, 7, 7, 0, -1, -1, '0, '0);
    request(1'b0, 32'h0000_1040, 1'b1, LINE_A);
    window(1'b0, 10, 7, 7, 0, -1, -1, '0, '0);

    // Request while busy is dropped
    request(1'b0, 32'h0000_0040, 1'b1, LINE_A);
    window(1'b0, 12, 7, 7, 4, 3, -1, '0, '0);

    // Reset during BURST
    request(1'b0, 32'h0000_0040, 1'b0, '0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst ready", ia.mem_ready_o, 0);
    check("midrst busy",  ia.busy_o,      0);
    check("midrst data",  ia.mem_data_o,  0);
    check("midrst drop",  ia.req_drop_o,  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    request(1'b0, 32'h0000_0040, 1'b1, LINE_A);
    window(1'b0, 10, 7, 7, 0, -1, -1, '0, '0);

    // Write before beat 3 is seen; write in beat 3's cycle is not
    request(1'b0, 32'h0000_0040, 1'b1, LINE_AD);
    window(1'b0, 10, 7, 7, 0, -1, 3, 10'h13, 32'hDEAD_BEEF);
    prog(1'b0, 10'h13, 32'hA000_0003);
    request(1'b0, 32'h0000_0040, 1'b1, LINE_A);
    window(1'b0, 10, 7, 7, 0, -1, 6, 10'h13, 32'hDEAD_BEEF);
    request(1'b0, 32'h0000_0040, 1'b1, LINE_AD);
    window(1'b0, 10, 7, 7, 0, -1, -1, '0, '0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
